// File: rtl/id_queue.sv
// Instruction queue with registered decode stage for a RV32I front end.
// Define ID_QUEUE_MULDIV_EN to accept M-extension (funct7=0000001) R-type ops.
module id_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             inst_valid_i,
    output logic             inst_ready_o,
    input  logic             ex_jump_flag_i,
    output logic [4:0]       reg1_raddr_o,
    output logic [4:0]       reg2_raddr_o,
    input  logic [31:0]      reg1_rdata_i,
    input  logic [31:0]      reg2_rdata_i,
    output logic             dec_valid_o,
    input  logic             dec_ready_i,
    output logic [31:0]      inst_o,
    output logic [31:0]      inst_addr_o,
    output logic [31:0]      op1_o,
    output logic [31:0]      op2_o,
    output logic [31:0]      op1_jump_o,
    output logic [31:0]      op2_jump_o,
    output logic             reg_we_o,
    output logic [4:0]       reg_waddr_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = (CNT_W > 1) ? CNT_W - 1 : 1;

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_addr [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty        = (count_o == '0);
    assign inst_ready_o = (count_o < CNT_W'(DEPTH));
    assign push         = inst_valid_i && inst_ready_o;
    assign pop          = !empty && (!dec_valid_o || dec_ready_i);

    always_ff @(posedge clk) begin
        if (push && !ex_jump_flag_i) begin
            mem_inst[wptr] <= inst_i;
            mem_addr[wptr] <= inst_addr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else if (ex_jump_flag_i) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count_o <= count_o + 1'b1;
                2'b01:   count_o <= count_o - 1'b1;
                default: count_o <= count_o;
            endcase
        end
    end

    // Head-of-queue decode
    logic [31:0] hi;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  f_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign hi    = mem_inst[rptr];
    assign pc    = mem_addr[rptr];
    assign opc   = hi[6:0];
    assign f3    = hi[14:12];
    assign f7    = hi[31:25];
    assign f_rd  = hi[11:7];
    assign f_rs1 = hi[19:15];
    assign f_rs2 = hi[24:20];
    assign imm_i = {{20{hi[31]}}, hi[31:20]};
    assign imm_s = {{20{hi[31]}}, hi[31:25], hi[11:7]};
    assign imm_b = {{20{hi[31]}}, hi[7], hi[30:25], hi[11:8], 1'b0};
    assign imm_j = {{12{hi[31]}}, hi[19:12], hi[20], hi[30:21], 1'b0};
    assign imm_u = {hi[31:12], 12'b0};

    logic is_opimm, is_load, is_op, is_store, is_branch;
    logic is_jal, is_jalr, is_lui, is_auipc, is_fence, is_sys;

    assign is_opimm  = (opc == 7'b0010011);
    assign is_load   = (opc == 7'b0000011);
    assign is_op     = (opc == 7'b0110011);
    assign is_store  = (opc == 7'b0100011);
    assign is_branch = (opc == 7'b1100011);
    assign is_jal    = (opc == 7'b1101111);
    assign is_jalr   = (opc == 7'b1100111);
    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);
    assign is_fence  = (opc == 7'b0001111);
    assign is_sys    = (opc == 7'b1110011);

    logic opimm_ok, load_ok, r_ok, st_ok, br_ok;
    logic md, md_div;

    assign opimm_ok = (f3 == 3'b001) ? (f7 == 7'h00) :
                      (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) :
                      1'b1;
    assign load_ok  = (f3 != 3'b011) && (f3[2:1] != 2'b11);
    assign r_ok     = (f7 == 7'h00) ||
                      (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
    assign st_ok    = !f3[2] && (f3 != 3'b011);
    assign br_ok    = (f3[2:1] != 2'b01);
`ifdef ID_QUEUE_MULDIV_EN
    assign md       = (f7 == 7'h01);
`else
    assign md       = 1'b0;
`endif
    // DIV/REM are multi-cycle in execute and hand back a pc+4 resume target
    assign md_div   = md && f3[2];

    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] d_op1, d_op2, d_j1, d_j2;
    logic        d_we;
    logic        d_ill;

    always_comb begin
        rs1   = '0;
        rs2   = '0;
        d_op1 = '0;
        d_op2 = '0;
        d_j1  = '0;
        d_j2  = '0;
        d_we  = 1'b0;
        d_ill = 1'b0;
        unique case (1'b1)
            is_opimm, is_load: begin
                if ((is_opimm && opimm_ok) || (is_load && load_ok)) begin
                    rs1   = f_rs1;
                    d_op1 = reg1_rdata_i;
                    d_op2 = imm_i;
                    d_we  = 1'b1;
                end else d_ill = 1'b1;
            end
            is_op: begin
                if (r_ok || md) begin
                    rs1   = f_rs1;
                    rs2   = f_rs2;
                    d_op1 = reg1_rdata_i;
                    d_op2 = reg2_rdata_i;
                    d_we  = !md_div;
                    if (md_div) begin
                        d_j1 = pc;
                        d_j2 = 32'd4;
                    end
                end else d_ill = 1'b1;
            end
            is_store: begin
                if (st_ok) begin
                    rs1   = f_rs1;
                    rs2   = f_rs2;
                    d_op1 = reg1_rdata_i;
                    d_op2 = imm_s;
                end else d_ill = 1'b1;
            end
            is_branch: begin
                if (br_ok) begin
                    rs1   = f_rs1;
                    rs2   = f_rs2;
                    d_op1 = reg1_rdata_i;
                    d_op2 = reg2_rdata_i;
                    d_j1  = pc;
                    d_j2  = imm_b;
                end else d_ill = 1'b1;
            end
            is_jal: begin
                d_op1 = pc;
                d_op2 = 32'd4;
                d_j1  = pc;
                d_j2  = imm_j;
                d_we  = 1'b1;
            end
            is_jalr: begin
                if (f3 == 3'b000) begin
                    rs1   = f_rs1;
                    d_op1 = pc;
                    d_op2 = 32'd4;
                    d_j1  = reg1_rdata_i;
                    d_j2  = imm_i;
                    d_we  = 1'b1;
                end else d_ill = 1'b1;
            end
            is_lui: begin
                d_op1 = imm_u;
                d_we  = 1'b1;
            end
            is_auipc: begin
                d_op1 = pc;
                d_op2 = imm_u;
                d_we  = 1'b1;
            end
            is_fence: begin
                if (f3[2:1] == 2'b00) begin
                    d_j1 = pc;
                    d_j2 = 32'd4;
                end else d_ill = 1'b1;
            end
            is_sys: begin
                if (f3[1:0] != 2'b00) begin
                    d_we = 1'b1;
                    if (!f3[2]) begin
                        rs1   = f_rs1;
                        d_op1 = reg1_rdata_i;
                    end else d_op1 = {27'b0, f_rs1};
                end else d_ill = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign reg1_raddr_o = empty ? 5'd0 : rs1;
    assign reg2_raddr_o = empty ? 5'd0 : rs2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_valid_o <= 1'b0;
            inst_o      <= '0;
            inst_addr_o <= '0;
            op1_o       <= '0;
            op2_o       <= '0;
            op1_jump_o  <= '0;
            op2_jump_o  <= '0;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            illegal_o   <= 1'b0;
        end else if (ex_jump_flag_i) begin
            dec_valid_o <= 1'b0;
        end else if (pop) begin
            dec_valid_o <= 1'b1;
            inst_o      <= hi;
            inst_addr_o <= pc;
            op1_o       <= d_op1;
            op2_o       <= d_op2;
            op1_jump_o  <= d_j1;
            op2_jump_o  <= d_j2;
            reg_we_o    <= d_we;
            reg_waddr_o <= d_we ? f_rd : 5'd0;
            illegal_o   <= d_ill;
        end else if (dec_ready_i) begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_queue.sv
// Self-checking bench for id_queue: directed scenarios plus a random
// stream compared against a queue-based reference model.
module tb_id_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
`ifdef ID_QUEUE_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [31:0]      inst_i;
    logic [31:0]      inst_addr_i;
    logic             inst_valid_i;
    logic             inst_ready_o;
    logic             ex_jump_flag_i;
    logic [4:0]       reg1_raddr_o;
    logic [4:0]       reg2_raddr_o;
    logic [31:0]      reg1_rdata_i;
    logic [31:0]      reg2_rdata_i;
    logic             dec_valid_o;
    logic             dec_ready_i;
    logic [31:0]      inst_o;
    logic [31:0]      inst_addr_o;
    logic [31:0]      op1_o;
    logic [31:0]      op2_o;
    logic [31:0]      op1_jump_o;
    logic [31:0]      op2_jump_o;
    logic             reg_we_o;
    logic [4:0]       reg_waddr_o;
    logic             illegal_o;
    logic [CNT_W-1:0] count_o;

    id_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
        .ex_jump_flag_i(ex_jump_flag_i),
        .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
        .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .op1_o(op1_o), .op2_o(op2_o),
        .op1_jump_o(op1_jump_o), .op2_jump_o(op2_jump_o),
        .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
        .illegal_o(illegal_o), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] regs [32];
    assign reg1_rdata_i = regs[reg1_raddr_o];
    assign reg2_rdata_i = regs[reg2_raddr_o];

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] j1;
        logic [31:0] j2;
        logic        we;
        logic [4:0]  waddr;
        logic        ill;
        logic [4:0]  r1;
        logic [4:0]  r2;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } ent_t;

    ent_t mq[$];
    bit   ov;
    exp_t oe;
    bit   m_pushed;
    int   total = 0;
    int   bad = 0;

    function automatic logic [31:0] sx(logic [31:0] v, int bits);
        logic signed [31:0] t;
        t = v << (32 - bits);
        return t >>> (32 - bits);
    endfunction

    // Reference decode: class table written from the ISA field rules
    function automatic exp_t ref_decode(logic [31:0] x, logic [31:0] pc);
        exp_t e;
        int f3, f7;
        logic [4:0] rd, s1, s2;
        bit ok, mdo;
        logic [31:0] ii, is, ib, ij, iu;
        f3 = int'(x[14:12]);
        f7 = int'(x[31:25]);
        rd = x[11:7];
        s1 = x[19:15];
        s2 = x[24:20];
        ii = sx(x >> 20, 12);
        is = sx(((x >> 25) << 5) | ((x >> 7) & 31), 12);
        ib = sx((((x >> 31) & 1) << 12) | (((x >> 7) & 1) << 11) |
                (((x >> 25) & 63) << 5) | (((x >> 8) & 15) << 1), 13);
        ij = sx((((x >> 31) & 1) << 20) | (((x >> 12) & 255) << 12) |
                (((x >> 20) & 1) << 11) | (((x >> 21) & 1023) << 1), 21);
        iu = x & 32'hFFFF_F000;
        e = '0;
        ok = 1;
        case (x[6:0])
            7'h13, 7'h03: begin
                if (x[6:0] == 7'h13)
                    ok = (f3 == 1) ? (f7 == 0) :
                         (f3 == 5) ? (f7 == 0 || f7 == 32) : 1;
                else
                    ok = f3 inside {0, 1, 2, 4, 5};
                e.r1 = s1; e.op1 = regs[s1]; e.op2 = ii; e.we = 1;
            end
            7'h33: begin
                mdo = MD_EN && f7 == 1;
                ok = f7 == 0 || (f7 == 32 && f3 inside {0, 5}) || mdo;
                e.r1 = s1; e.r2 = s2;
                e.op1 = regs[s1]; e.op2 = regs[s2];
                e.we = !(mdo && f3 >= 4);
                if (mdo && f3 >= 4) begin e.j1 = pc; e.j2 = 4; end
            end
            7'h23: begin
                ok = f3 <= 2;
                e.r1 = s1; e.r2 = s2;
                e.op1 = regs[s1]; e.op2 = is;
            end
            7'h63: begin
                ok = !(f3 inside {2, 3});
                e.r1 = s1; e.r2 = s2;
                e.op1 = regs[s1]; e.op2 = regs[s2];
                e.j1 = pc; e.j2 = ib;
            end
            7'h6f: begin
                e.op1 = pc; e.op2 = 4; e.j1 = pc; e.j2 = ij; e.we = 1;
            end
            7'h67: begin
                ok = f3 == 0;
                e.r1 = s1; e.op1 = pc; e.op2 = 4;
                e.j1 = regs[s1]; e.j2 = ii; e.we = 1;
            end
            7'h37: begin e.op1 = iu; e.we = 1; end
            7'h17: begin e.op1 = pc; e.op2 = iu; e.we = 1; end
            7'h0f: begin
                ok = f3 <= 1;
                e.j1 = pc; e.j2 = 4;
            end
            7'h73: begin
                ok = !(f3 inside {0, 4});
                e.we = 1;
                if (f3 < 4) begin e.r1 = s1; e.op1 = regs[s1]; end
                else e.op1 = 32'(s1);
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.ill = 1;
        end
        e.inst = x;
        e.addr = pc;
        e.waddr = e.we ? rd : 5'd0;
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        ov = 0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] i,
                              input logic [31:0] a, input bit r,
                              input bit f);
        bit can_pop, can_push;
        m_pushed = 0;
        if (f) begin
            model_reset();
            return;
        end
        can_pop  = mq.size() != 0 && (!ov || r);
        can_push = v && mq.size() < DEPTH;
        if (can_pop) begin
            oe = ref_decode(mq[0].inst, mq[0].addr);
            void'(mq.pop_front());
            ov = 1;
        end else if (r) ov = 0;
        if (can_push) begin
            mq.push_back('{inst: i, addr: a});
            m_pushed = 1;
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] i,
                         input logic [31:0] a, input bit r, input bit f);
        inst_valid_i   = v;
        inst_i         = i;
        inst_addr_i    = a;
        dec_ready_i    = r;
        ex_jump_flag_i = f;
        @(posedge clk);
        model_step(v, i, a, r, f);
        #1;
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h33, 7'h23, 7'h63, 7'h6f,
                                 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73};
        logic [31:0] x;
        x = $urandom();
        if ($urandom_range(0, 9) == 0) return x;
        x[6:0] = ops[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            2: x[31:25] = 7'h01;
            default: ;
        endcase
        return x;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        inst_valid_i = 0; inst_i = 0; inst_addr_i = 0;
        dec_ready_i = 0; ex_jump_flag_i = 0;
        #1 rst = 1'b0;
        #2;
        total++;
        if (count_o !== 0 || dec_valid_o !== 0 || reg_we_o !== 0 ||
            illegal_o !== 0) begin
            bad++;
            $display("FAIL reset_ctrl: got cnt=%0d v=%b we=%b ill=%b want 0",
                     count_o, dec_valid_o, reg_we_o, illegal_o);
        end
        total++;
        if (inst_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", inst_ready_o);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_addi();
        cycle(0, 0, 0, 1, 1);
        cycle(1, 32'h0050_0093, 32'h0, 1, 0);
        total++;
        if (dec_valid_o !== 0 || count_o !== 1) begin
            bad++;
            $display("FAIL addi_edge1: got v=%b cnt=%0d want v=0 cnt=1",
                     dec_valid_o, count_o);
        end
        cycle(0, 0, 0, 1, 0);
        total++;
        if (dec_valid_o !== 1 || op1_o !== 0 || op2_o !== 5 ||
            reg_we_o !== 1 || reg_waddr_o !== 1 || illegal_o !== 0) begin
            bad++;
            $display("FAIL addi_dec: got v=%b op1=%h op2=%h we=%b wa=%0d ill=%b want 1,0,5,1,1,0",
                     dec_valid_o, op1_o, op2_o, reg_we_o, reg_waddr_o,
                     illegal_o);
        end
    endtask

    task automatic test_full();
        logic [31:0] ins [6];
        int k;
        for (int n = 0; n < 6; n++)
            ins[n] = (32'(n + 10) << 20) | (32'(n + 1) << 7) | 32'h13;
        cycle(0, 0, 0, 1, 1);
        k = 0;
        for (int c = 0; c < 8; c++) begin
            cycle(1, ins[k], 32'(k * 4), 0, 0);
            if (m_pushed) k++;
        end
        total++;
        if (count_o !== 4 || inst_ready_o !== 0 || dec_valid_o !== 1 ||
            inst_o !== ins[0]) begin
            bad++;
            $display("FAIL full_hold: got cnt=%0d rdy=%b v=%b inst=%h want 4,0,1,%h",
                     count_o, inst_ready_o, dec_valid_o, inst_o, ins[0]);
        end
        cycle(1, ins[k], 32'(k * 4), 1, 0);
        if (m_pushed) k++;
        total++;
        if (count_o !== 3 || inst_ready_o !== 1 || inst_o !== ins[1]) begin
            bad++;
            $display("FAIL full_pulse: got cnt=%0d rdy=%b inst=%h want 3,1,%h",
                     count_o, inst_ready_o, inst_o, ins[1]);
        end
        cycle(1, ins[k], 32'(k * 4), 0, 0);
        total++;
        if (count_o !== 4 || inst_ready_o !== 0) begin
            bad++;
            $display("FAIL full_sixth: got cnt=%0d rdy=%b want 4,0",
                     count_o, inst_ready_o);
        end
    endtask

    task automatic test_flush();
        cycle(0, 0, 0, 1, 1);
        for (int n = 0; n < 4; n++)
            cycle(1, 32'h0000_0013, 32'(n * 4), 0, 0);
        total++;
        if (count_o !== 3 || dec_valid_o !== 1) begin
            bad++;
            $display("FAIL flush_pre: got cnt=%0d v=%b want 3,1",
                     count_o, dec_valid_o);
        end
        cycle(1, 32'h0010_0093, 32'h40, 0, 1);
        total++;
        if (count_o !== 0 || dec_valid_o !== 0) begin
            bad++;
            $display("FAIL flush_now: got cnt=%0d v=%b want 0,0",
                     count_o, dec_valid_o);
        end
        cycle(0, 0, 0, 1, 0);
        total++;
        if (count_o !== 0 || dec_valid_o !== 0) begin
            bad++;
            $display("FAIL flush_drop: got cnt=%0d v=%b want 0,0",
                     count_o, dec_valid_o);
        end
    endtask

    task automatic test_branch();
        cycle(0, 0, 0, 1, 1);
        cycle(1, 32'hFE20_8CE3, 32'h100, 1, 0);
        cycle(0, 0, 0, 1, 0);
        total++;
        if (op1_jump_o !== 32'h100 || op2_jump_o !== 32'hFFFF_FFF8 ||
            op1_o !== regs[1] || op2_o !== regs[2] ||
            reg_we_o !== 0 || reg_waddr_o !== 0 || dec_valid_o !== 1) begin
            bad++;
            $display("FAIL beq: got j1=%h j2=%h op1=%h op2=%h we=%b wa=%0d",
                     op1_jump_o, op2_jump_o, op1_o, op2_o, reg_we_o,
                     reg_waddr_o);
        end
    endtask

    task automatic test_mul();
        logic ew, ei;
        logic [4:0] ea;
        ew = MD_EN;
        ei = !MD_EN;
        ea = MD_EN ? 5'd3 : 5'd0;
        cycle(0, 0, 0, 1, 1);
        cycle(1, 32'h0220_81B3, 32'h200, 1, 0);
        cycle(0, 0, 0, 1, 0);
        total++;
        if (reg_we_o !== ew || illegal_o !== ei || reg_waddr_o !== ea ||
            dec_valid_o !== 1) begin
            bad++;
            $display("FAIL mul: got we=%b ill=%b wa=%0d v=%b want %b,%b,%0d,1",
                     reg_we_o, illegal_o, reg_waddr_o, dec_valid_o,
                     ew, ei, ea);
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 0, 0, 1, 1);
        for (int n = 0; n < 3; n++)
            cycle(1, 32'h0020_8113, 32'(n * 4), 0, 0);
        total++;
        if (count_o !== 2 || dec_valid_o !== 1) begin
            bad++;
            $display("FAIL arst_pre: got cnt=%0d v=%b want 2,1",
                     count_o, dec_valid_o);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (count_o !== 0 || dec_valid_o !== 0 || reg_we_o !== 0 ||
            illegal_o !== 0 || reg_waddr_o !== 0 ||
            reg1_raddr_o !== 0) begin
            bad++;
            $display("FAIL arst_ctrl: got cnt=%0d v=%b we=%b ill=%b wa=%0d ra=%0d want 0",
                     count_o, dec_valid_o, reg_we_o, illegal_o,
                     reg_waddr_o, reg1_raddr_o);
        end
        total++;
        if ({inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o,
             op2_jump_o} !== '0) begin
            bad++;
            $display("FAIL arst_data: got %h %h %h %h %h %h want 0",
                     inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o,
                     op2_jump_o);
        end
        #1 rst = 1'b1;
        model_reset();
        cycle(1, 32'h0050_0093, 32'h80, 1, 0);
        total++;
        if (count_o !== 1) begin
            bad++;
            $display("FAIL arst_first_push: got cnt=%0d want 1", count_o);
        end
    endtask

    task automatic test_random();
        bit v, r, f;
        logic [31:0] x, a;
        exp_t h;
        logic [198:0] got, want;
        logic [4:0] e1, e2;
        for (int c = 0; c < 400; c++) begin
            v = $urandom_range(0, 3) != 0;
            r = $urandom_range(0, 2) != 0;
            f = $urandom_range(0, 31) == 0;
            x = gen_inst();
            a = $urandom() & 32'hFFFF_FFFC;
            cycle(v, x, a, r, f);
            total++;
            if (count_o !== CNT_W'(mq.size()) ||
                inst_ready_o !== (mq.size() < DEPTH)) begin
                bad++;
                $display("FAIL rnd_cnt[%0d]: got cnt=%0d rdy=%b want %0d",
                         c, count_o, inst_ready_o, mq.size());
            end
            total++;
            if (dec_valid_o !== ov) begin
                bad++;
                $display("FAIL rnd_valid[%0d]: got %b want %b",
                         c, dec_valid_o, ov);
            end
            e1 = 0;
            e2 = 0;
            if (mq.size() != 0) begin
                h = ref_decode(mq[0].inst, mq[0].addr);
                e1 = h.r1;
                e2 = h.r2;
            end
            total++;
            if (reg1_raddr_o !== e1 || reg2_raddr_o !== e2) begin
                bad++;
                $display("FAIL rnd_raddr[%0d]: got %0d,%0d want %0d,%0d",
                         c, reg1_raddr_o, reg2_raddr_o, e1, e2);
            end
            if (ov) begin
                got  = {inst_o, inst_addr_o, op1_o, op2_o, op1_jump_o,
                        op2_jump_o, reg_we_o, reg_waddr_o, illegal_o};
                want = {oe.inst, oe.addr, oe.op1, oe.op2, oe.j1, oe.j2,
                        oe.we, oe.waddr, oe.ill};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL rnd_out[%0d]: got %h want %h",
                             c, got, want);
                end
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 32; n++) regs[n] = $urandom();
        regs[0] = 32'h0;
        test_reset();
        test_addi();
        test_full();
        test_flush();
        test_branch();
        test_mul();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
